// File: rtl/divider_unit_if.sv
// Request/response bundle shared by the divider and multiplier units of the MDU.
// Optional feature macro: DIVIDER_DIVZERO_FAST_EN adds the div_zero flag.
interface divider_unit_if #(
  parameter int parallelism = 32
);
  logic                   valid;
  logic                   usigned;
  logic [parallelism-1:0] dividend;
  logic [parallelism-1:0] divisor;
  logic [parallelism-1:0] quotient;
  logic [parallelism-1:0] remainder;
  logic                   res_ready;
`ifdef DIVIDER_DIVZERO_FAST_EN
  logic                   div_zero;

  modport master (
    output valid, usigned, dividend, divisor,
    input  quotient, remainder, res_ready, div_zero
  );
  modport slave (
    input  valid, usigned, dividend, divisor,
    output quotient, remainder, res_ready, div_zero
  );
`else
  modport master (
    output valid, usigned, dividend, divisor,
    input  quotient, remainder, res_ready
  );
  modport slave (
    input  valid, usigned, dividend, divisor,
    output quotient, remainder, res_ready
  );
`endif
endinterface

// File: rtl/divider_unit.sv
// Sequential radix-2 restoring divider, one quotient bit per cycle.
// Signed mode divides magnitudes and fixes signs at the end (remainder follows
// the dividend). Optional feature macro: DIVIDER_DIVZERO_FAST_EN short-cuts a
// zero divisor straight to the result and raises div_zero.
module divider_unit #(
  parameter int parallelism = 32
) (
  input logic           clk,
  input logic           rst_n,
  divider_unit_if.slave bus
);
  localparam int N  = parallelism;
  localparam int CW = $clog2(N);

  typedef enum logic [2:0] {IDLE, LOAD, ITER, FIXSIGN, DONE} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   quo_q, quo_d;         // dividend, then quotient bits
  logic [N-1:0]   dvs_q, dvs_d;         // divisor, then its magnitude
  logic [N:0]     rem_q, rem_d;         // partial remainder
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           usigned_q, usigned_d;
  logic           sgn_quo_q, sgn_quo_d;
  logic           sgn_rem_q, sgn_rem_d;
  logic [N-1:0]   quotient_q, quotient_d;
  logic [N-1:0]   remainder_q, remainder_d;
`ifdef DIVIDER_DIVZERO_FAST_EN
  logic           div_zero_q, div_zero_d;
`endif

  logic [N:0]     rem_sh;
  logic [N+1:0]   trial;
  logic           tc;
  logic           dvs_zero;

  // Shifted remainder takes the next dividend bit; trial sign bit decides restore.
  assign rem_sh   = {rem_q[N-1:0], quo_q[N-1]};
  assign trial    = {1'b0, rem_sh} - {2'b00, dvs_q};
  assign tc       = (cnt_q == CW'(N - 1));
  assign dvs_zero = (dvs_q == '0);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.valid) state_d = LOAD;
      LOAD: begin
`ifdef DIVIDER_DIVZERO_FAST_EN
        state_d = dvs_zero ? FIXSIGN : ITER;
`else
        state_d = ITER;
`endif
      end
      ITER:    if (tc) state_d = FIXSIGN;
      FIXSIGN: state_d = DONE;
      DONE:    state_d = bus.valid ? LOAD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode: the result pulse is exactly the DONE cycle.
  always_comb begin
    bus.res_ready = (state_q == DONE);
  end

  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
`ifdef DIVIDER_DIVZERO_FAST_EN
  assign bus.div_zero  = div_zero_q;
`endif

  // Datapath next-state: operand capture, magnitude, iteration and sign fix.
  always_comb begin
    // NOTE: every target gets a hold default first, so no path leaves a latch.
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    usigned_d   = usigned_q;
    sgn_quo_d   = sgn_quo_q;
    sgn_rem_d   = sgn_rem_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
`ifdef DIVIDER_DIVZERO_FAST_EN
    div_zero_d  = div_zero_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.valid) begin
          quo_d     = bus.dividend;
          dvs_d     = bus.divisor;
          usigned_d = bus.usigned;
        end
      end
      LOAD: begin
        rem_d     = '0;
        cnt_d     = '0;
        sgn_quo_d = !usigned_q && (quo_q[N-1] ^ dvs_q[N-1]);
        sgn_rem_d = !usigned_q && quo_q[N-1];
        if (!usigned_q && quo_q[N-1]) quo_d = -quo_q;
        if (!usigned_q && dvs_q[N-1]) dvs_d = -dvs_q;
`ifdef DIVIDER_DIVZERO_FAST_EN
        // Zero divisor: preload the fixed result and bypass the iterations.
        if (dvs_zero) begin
          quo_d     = '1;
          rem_d     = {1'b0, quo_q};
          sgn_quo_d = 1'b0;
          sgn_rem_d = 1'b0;
        end
`endif
      end
      ITER: begin
        cnt_d = cnt_q + CW'(1);
        if (!trial[N+1]) begin
          rem_d = trial[N:0];
          quo_d = {quo_q[N-2:0], 1'b1};
        end else begin
          rem_d = rem_sh;
          quo_d = {quo_q[N-2:0], 1'b0};
        end
      end
      FIXSIGN: begin
        quotient_d  = sgn_quo_q ? -quo_q : quo_q;
        remainder_d = sgn_rem_q ? -rem_q[N-1:0] : rem_q[N-1:0];
`ifdef DIVIDER_DIVZERO_FAST_EN
        div_zero_d  = dvs_zero;
`endif
      end
      default: ;
    endcase
  end

  // Datapath registers; reset clears results and discards any in-flight work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      usigned_q   <= 1'b0;
      sgn_quo_q   <= 1'b0;
      sgn_rem_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
`ifdef DIVIDER_DIVZERO_FAST_EN
      div_zero_q  <= 1'b0;
`endif
    end else begin
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      usigned_q   <= usigned_d;
      sgn_quo_q   <= sgn_quo_d;
      sgn_rem_q   <= sgn_rem_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
`ifdef DIVIDER_DIVZERO_FAST_EN
      div_zero_q  <= div_zero_d;
`endif
    end
  end
endmodule

// File: tb/tb_divider_unit.sv
// Directed plus randomized bench for divider_unit (N=32) with an arithmetic
// reference model. Honours DIVIDER_DIVZERO_FAST_EN when defined.
module tb_divider_unit;
  localparam int N = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  divider_unit_if #(.parallelism(N)) bus ();

  divider_unit #(.parallelism(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit integer division, truncating toward zero.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input bit u,
                                output logic [31:0] q, output logic [31:0] r, output bit known);
    longint sa, sb;
    known = 1'b1;
    if (b == 32'd0) begin
      q = '1;
      r = a;
`ifndef DIVIDER_DIVZERO_FAST_EN
      known = u;
`endif
    end else begin
      if (u) begin
        sa = longint'({32'd0, a});
        sb = longint'({32'd0, b});
      end else begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end
  endfunction

  function automatic int exp_latency(input logic [31:0] b);
`ifdef DIVIDER_DIVZERO_FAST_EN
    if (b == 32'd0) return 3;
`endif
    return N + 3;
  endfunction

  // Present a request for one edge (edge 0); returns #1 after that edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit u);
    @(negedge clk);
    bus.valid    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    bus.usigned  = u;
    @(posedge clk);
    #1 bus.valid = 1'b0;
  endtask

  // Count cycles (LOAD = 1) until res_ready, bounded.
  task automatic wait_result(inout int cyc);
    while (bus.res_ready !== 1'b1 && cyc < 200) begin
      @(posedge clk);
      #1 cyc++;
    end
  endtask

  task automatic check_result(input string tag, input logic [31:0] a, input logic [31:0] b,
                              input bit u, input int cyc);
    logic [31:0] eq, er;
    bit          known;
    model(a, b, u, eq, er, known);
    check({tag, " latency"}, 64'(cyc), 64'(exp_latency(b)));
    if (known) begin
      check({tag, " quotient"}, 64'(bus.quotient), 64'(eq));
      check({tag, " remainder"}, 64'(bus.remainder), 64'(er));
    end
`ifdef DIVIDER_DIVZERO_FAST_EN
    check({tag, " div_zero"}, 64'(bus.div_zero), 64'(b == 32'd0));
`endif
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b, input bit u, input string tag);
    int cyc = 1;
    issue(a, b, u);
    wait_result(cyc);
    check_result(tag, a, b, u, cyc);
    @(posedge clk);
    #1 check({tag, " pulse width"}, 64'(bus.res_ready), 64'd0);
  endtask

  initial begin
    int          cyc;
    int          rr_seen;
    logic [31:0] ra, rb;
    bit          ru;

    rst_n        = 1'b0;
    bus.valid    = 1'b0;
    bus.usigned  = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    #12;
    check("reset quotient", 64'(bus.quotient), 64'd0);
    check("reset remainder", 64'(bus.remainder), 64'd0);
    check("reset res_ready", 64'(bus.res_ready), 64'd0);
`ifdef DIVIDER_DIVZERO_FAST_EN
    check("reset div_zero", 64'(bus.div_zero), 64'd0);
`endif
    @(negedge clk) rst_n = 1'b1;

    // Directed arithmetic cases.
    run(32'd100, 32'd7, 1'b1, "u 100/7");
    run(32'(-100), 32'd7, 1'b0, "s -100/7");
    run(32'd100, 32'(-7), 1'b0, "s 100/-7");
    run(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "s min/-1");
    run(32'hFFFF_FFFF, 32'd1, 1'b1, "u max/1");
    run(32'd1234, 32'd0, 1'b1, "u 1234/0");
    run(32'(-5), 32'd0, 1'b0, "s -5/0");
    run(32'd5, 32'd9, 1'b1, "u 5/9");

    // Back-to-back via DONE, with a stray valid during ITER of the second request.
    cyc = 1;
    issue(32'd9, 32'd2, 1'b1);
    wait_result(cyc);
    check_result("b2b 9/2", 32'd9, 32'd2, 1'b1, cyc);
    cyc = 1;
    issue(32'd50, 32'd5, 1'b1);
    repeat (5) begin
      @(posedge clk);
      #1 cyc++;
    end
    issue(32'd7, 32'd7, 1'b0);
    cyc++;
    wait_result(cyc);
    check_result("b2b 50/5", 32'd50, 32'd5, 1'b1, cyc);
    rr_seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1 if (bus.res_ready) rr_seen++;
    end
    check("ignored valid no extra result", 64'(rr_seen), 64'd0);

    // Asynchronous reset in the middle of ITER.
    issue(32'd1000, 32'd3, 1'b1);
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("mid reset quotient", 64'(bus.quotient), 64'd0);
    check("mid reset remainder", 64'(bus.remainder), 64'd0);
    check("mid reset res_ready", 64'(bus.res_ready), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    rr_seen = 0;
    repeat (45) begin
      @(posedge clk);
      #1 if (bus.res_ready) rr_seen++;
    end
    check("discarded result", 64'(rr_seen), 64'd0);
    run(32'd81, 32'd9, 1'b1, "post reset 81/9");

    // Randomized operands over a spread of divisor magnitudes.
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if (rb == 32'd0) rb = 32'd1;
      ru = 1'($urandom_range(0, 1));
      run(ra, rb, ru, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/divider_unit.md
# divider_unit

Sequential radix-2 restoring integer divider, the division counterpart of the multiplier unit in the multiply/divide block. It accepts a dividend/divisor pair with a `valid` strobe and an `usigned` mode bit. It iterates one quotient bit per cycle and returns quotient and remainder with a one-cycle `res_ready` pulse. It sits beside the multiplier behind the same request/ready handshake, so the top-level MDU steers operands to either unit identically.

## Interface
- `parallelism`, default 32: operand width N; N ≥ 2.
- `clk` input 1: single clock, all flops rising-edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `valid` input 1: request strobe; sampled only in IDLE or DONE.
- `usigned` input 1: 1 selects unsigned division, 0 selects two's-complement signed division; sampled with `valid`.
- `dividend` input N: numerator; sampled with `valid`.
- `divisor` input N: denominator; sampled with `valid`.
- `quotient` output N: result quotient; registered.
- `remainder` output N: result remainder; registered.
- `res_ready` output 1: one-cycle pulse, high while `quotient` and `remainder` hold the new result.
- `div_zero` output 1: present only with `DIVIDER_DIVZERO_FAST_EN`; registered; high alongside the result of a zero-divisor request.

## Operation
- States: IDLE, LOAD, ITER, FIXSIGN, DONE.
- IDLE: if `valid`=1, capture `dividend`, `divisor`, `usigned` and go to LOAD; otherwise stay.
- LOAD:
  - Signed mode: record sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend); replace each operand by its magnitude.
  - Unsigned mode: both signs are 0.
  - Clear the partial remainder (N+1 bits); clear the iteration counter; go to ITER.
- ITER, N cycles, counter 0..N-1:
  - Shift {rem, quo} left by 1.
  - Trial = rem − divisor_mag.
  - If trial ≥ 0, rem ← trial and quo LSB ← 1; else quo LSB ← 0.
  - tc is asserted when the counter = N-1; tc moves the FSM to FIXSIGN.
- FIXSIGN:
  - `quotient` ← sign_q ? −quo : quo.
  - `remainder` ← sign_r ? −rem : rem (low N bits).
  - Go to DONE.
- DONE:
  - `res_ready`=1 for this single cycle.
  - If `valid`=1, capture the new operands and go to LOAD (back-to-back); else go to IDLE.
- `valid` is ignored in LOAD, ITER and FIXSIGN; no queuing.
- `quotient` and `remainder` hold their value until the next FIXSIGN.
- Arithmetic rules:
  - Remainder takes the dividend's sign.
  - Signed −2^(N-1) / −1 gives quotient −2^(N-1) and remainder 0, with no trap.
- Divisor = 0 without the macro:
  - Unsigned mode: quotient all-ones, remainder = dividend, which falls out of the algorithm.
  - Signed mode: result is unspecified; only timing is checked.
- Reset, async, any state:
  - State goes to IDLE.
  - `quotient`, `remainder` go to 0; `res_ready` goes to 0; `div_zero` goes to 0.
  - The counter clears.
  - An in-flight division is discarded; no `res_ready` follows.

## Timing
- Edge 0: `valid` is sampled in IDLE or DONE.
- Cycles after edge 0:
  - Cycle 1: LOAD.
  - Cycles 2..N+1: ITER.
  - Cycle N+2: FIXSIGN.
  - Cycle N+3: DONE, `res_ready`=1.
- Latency is N+3 cycles: 35 for N=32.
- Results are valid from the start of DONE onward.
- Maximum throughput is one result per N+3 cycles, using back-to-back via DONE.

## Configuration
- `DIVIDER_DIVZERO_FAST_EN` defined:
  - In LOAD, divisor = 0 is detected and ITER is skipped; the FSM goes LOAD → FIXSIGN.
  - Result in both modes: `quotient` = all-ones (−1 signed), `remainder` = raw dividend.
  - `div_zero`=1 from FIXSIGN until the next FIXSIGN.
  - Latency is 3 cycles.
  - For nonzero divisors, `div_zero`=0.
- Not defined:
  - No `div_zero` port and no shortcut.
  - Zero divisors run the full N+3 cycles, with the results described in Operation.

## Test plan
- Unsigned 100 / 7, N=32 → `res_ready` exactly 35 cycles after the `valid` edge; `quotient`=14, `remainder`=2; `res_ready` width is 1 cycle.
- Signed −100 / 7 → quotient −14 (0xFFFFFFF2), remainder −2; then 100 / −7 → −14, 2.
- Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0. Unsigned 0xFFFFFFFF / 1 → 0xFFFFFFFF, 0.
- Back-to-back:
  - Requests: `valid` in DONE with 9/2, then the next request 50/5.
  - Response: second `res_ready` 35 cycles after the first; results 4,1 then 10,0.
  - A `valid` pulse during ITER is ignored.
- Assert `rst_n`=0 asynchronously mid-ITER → outputs immediately 0, no `res_ready`. A new request after release, 81/9, → 9, 0.
- Zero divisor, unsigned 1234 / 0:
  - With the macro: 1234 / 0 gives `res_ready` at cycle 3 with `quotient`=0xFFFFFFFF, `remainder`=1234, `div_zero`=1; signed −5 / 0 gives 0xFFFFFFFF, 0xFFFFFFFB.
  - Without the macro: cycle 35 with 0xFFFFFFFF, 1234.
